nb_update_engine: RTL and testbench
===================================

// Module: nb_update_engine
// PURPOSE
//   Parametrised four-register update network (a,b,c,d) with cross-coupled recurrences:
//   a=b+c, d=a-K_D, b=d+K_B, c=c+STEP. Runs a commanded number of steps in either
//   parallel (all RHS from pre-step values) or sequential (in-order) evaluation mode,
//   with a load port, wrap/saturate arithmetic and a sticky overflow flag.
//   Used as a reusable update-semantics engine and a bench target for assignment ordering.
// PARAMETERS
//   WIDTH     32  data width of a,b,c,d and load_data
//   CNT_W     16  width of steps and total_steps
//   INIT_A    30  reset value of a;  INIT_B 20 / INIT_C 15 / INIT_D 5 likewise
//   K_D       3   constant subtracted in d update
//   K_B       10  constant added in b update
//   STEP      1   increment applied to c
//   SATURATE  0   0: modulo 2^WIDTH arithmetic; 1: clamp to [0, 2^WIDTH-1]
// PORTS
//   clock        in   1      single clock, all state updates on posedge
//   reset        in   1      synchronous, active-high, highest priority
//   start        in   1      run request, accepted only in IDLE
//   steps        in   CNT_W  number of updates for the run, sampled with start
//   seq_mode     in   1      0 parallel, 1 sequential; sampled with start, held for run
//   load_valid   in   1      load request
//   load_sel     in   2      target register: 0 a, 1 b, 2 c, 3 d
//   load_data    in   WIDTH  value to load
//   load_ready   out  1      1 only in IDLE and reset low (combinational)
//   busy         out  1      1 in RUN
//   done         out  1      one-cycle pulse in DONE
//   a, b, c, d   out  WIDTH  registered state
//   ovf          out  1      sticky: any wrap/clamp since last clear
//   ovf_clr      in   1      clears ovf
//   total_steps  out  CNT_W  updates applied since reset, wraps at 2^CNT_W
// BEHAVIOUR
//   Reset: a..d<=INIT_*, state IDLE, busy=0, done=0, ovf=0, total_steps=0, remaining=0.
//   Reset asserted mid-run aborts immediately: no done pulse, no partial update that edge.
//   FSM IDLE/RUN/DONE:
//     IDLE: start -> latch steps into remaining, latch seq_mode; steps==0 -> DONE, else RUN.
//     RUN: each edge applies one update, remaining-=1, total_steps+=1;
//          edge applying update with remaining==1 -> DONE. start ignored.
//     DONE: done=1 for that cycle only; -> IDLE next edge. start ignored.
//   Latency: start at edge N, updates at edges N+1..N+S, done high the cycle after N+S.
//   Load: accepted when load_valid & load_ready; writes load_sel register at that edge.
//     Load and start in same IDLE cycle: both take effect; first update uses loaded value.
//     Load outside IDLE has no effect (no stall, no queue).
//   Parallel update: a'=b+c, d'=a-K_D, b'=d+K_B, c'=c+STEP (all RHS old values).
//   Sequential update (order a,d,b,c): a'=b+c, d'=a'-K_D, b'=d'+K_B, c'=c+STEP.
//   Arithmetic: SATURATE=0 wraps mod 2^WIDTH; SATURATE=1 adds clamp at 2^WIDTH-1,
//     subtract clamps at 0. Any wrap/clamp of any of the four results sets ovf.
//   ovf: set wins over ovf_clr in the same cycle; otherwise ovf_clr clears at edge.
// TESTING
//   Defaults, parallel, start steps=1 -> a=35,b=15,c=16,d=27; steps=2 -> a=31,b=37,c=17,d=32.
//   Defaults, seq_mode=1, steps=1 -> a=35,d=32,b=42,c=16; done 1 cycle after last update.
//   start steps=0 -> done pulses cycle after start, a..d unchanged, total_steps unchanged.
//   WIDTH=8, SATURATE=0: load c=255, a=1, steps=1 parallel -> c=0, d=254, ovf=1;
//     SATURATE=1 same stimulus -> c=255, d=0, ovf=1; ovf_clr alone -> ovf=0.
//   start steps=10, reset at 3rd RUN cycle -> next edge a..d=INIT, busy=0, no done pulse.
//   load_valid during RUN (load_sel=0, data=99) -> ignored, load_ready=0, a follows recurrence.

Source files
------------

// File: rtl/nb_update_engine.sv
// Four-register cross-coupled update engine (a=b+c, d=a-K_D, b=d+K_B, c=c+STEP) with
// parallel or sequential evaluation, a load port, wrap/saturate arithmetic and sticky overflow.
module nb_update_engine #(
  parameter int WIDTH    = 32,
  parameter int CNT_W    = 16,
  parameter int INIT_A   = 30,
  parameter int INIT_B   = 20,
  parameter int INIT_C   = 15,
  parameter int INIT_D   = 5,
  parameter int K_D      = 3,
  parameter int K_B      = 10,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] steps,
  input  logic             seq_mode,
  input  logic             load_valid,
  input  logic [1:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [CNT_W-1:0] total_steps
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] KD_VAL   = WIDTH'(K_D);
  localparam logic [WIDTH-1:0] KB_VAL   = WIDTH'(K_B);
  localparam logic [WIDTH-1:0] STEP_VAL = WIDTH'(STEP);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] remaining_reg;
  logic             mode_reg;
  logic [WIDTH-1:0] a_reg, b_reg, c_reg, d_reg;
  logic             ovf_reg;
  logic [CNT_W-1:0] total_reg;

  // Results carry the wrap/clamp flag in the top bit.
  logic [WIDTH:0] a_next, b_next, c_next, d_next;
  logic           upd_ovf;

  function automatic logic [WIDTH:0] add_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if ((SATURATE != 0) && s[WIDTH]) s = {1'b1, {WIDTH{1'b1}}};
    return s;
  endfunction

  function automatic logic [WIDTH:0] sub_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} - {1'b0, y};
    if ((SATURATE != 0) && s[WIDTH]) s = {1'b1, {WIDTH{1'b0}}};
    return s;
  endfunction

  // Sequential mode chains the freshly computed a into d, and that d into b.
  always_comb begin
    a_next  = add_op(b_reg, c_reg);
    d_next  = sub_op(mode_reg ? a_next[WIDTH-1:0] : a_reg, KD_VAL);
    b_next  = add_op(mode_reg ? d_next[WIDTH-1:0] : d_reg, KB_VAL);
    c_next  = add_op(c_reg, STEP_VAL);
    upd_ovf = a_next[WIDTH] | b_next[WIDTH] | c_next[WIDTH] | d_next[WIDTH];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      mode_reg      <= 1'b0;
      a_reg         <= WIDTH'(INIT_A);
      b_reg         <= WIDTH'(INIT_B);
      c_reg         <= WIDTH'(INIT_C);
      d_reg         <= WIDTH'(INIT_D);
      ovf_reg       <= 1'b0;
      total_reg     <= '0;
    end else begin
      unique case (state_reg)
        IDLE: begin
          if (load_valid) begin
            unique case (load_sel)
              2'd0: a_reg <= load_data;
              2'd1: b_reg <= load_data;
              2'd2: c_reg <= load_data;
              2'd3: d_reg <= load_data;
            endcase
          end
          if (start) begin
            remaining_reg <= steps;
            mode_reg      <= seq_mode;
            state_reg     <= (steps == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          a_reg         <= a_next[WIDTH-1:0];
          b_reg         <= b_next[WIDTH-1:0];
          c_reg         <= c_next[WIDTH-1:0];
          d_reg         <= d_next[WIDTH-1:0];
          remaining_reg <= remaining_reg - 1'b1;
          total_reg     <= total_reg + 1'b1;
          if (remaining_reg == CNT_W'(1)) state_reg <= DONE;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      // A new overflow in this edge beats a simultaneous clear.
      ovf_reg <= ((state_reg == RUN) && upd_ovf) || (ovf_reg && !ovf_clr);
    end
  end

  assign load_ready  = (state_reg == IDLE) && !reset;
  assign busy        = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign a           = a_reg;
  assign b           = b_reg;
  assign c           = c_reg;
  assign d           = d_reg;
  assign ovf         = ovf_reg;
  assign total_steps = total_reg;

endmodule

// File: tb/tb_nb_update_engine.sv
// Scoreboard bench: expected end-of-run state is queued at stimulus time and checked on each done pulse.
module tb_nb_update_engine;

  typedef struct {
    logic [31:0] a, b, c, d, ovf, total;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t qw[$];
  exp_t qs[$];

  // Default-parameter instance
  logic        reset0 = 1'b1, start0 = 1'b0, seq0 = 1'b0, lv0 = 1'b0, clr0 = 1'b0;
  logic [15:0] steps0 = '0;
  logic [1:0]  sel0 = '0;
  logic [31:0] data0 = '0;
  logic        ready0, busy0, done0, ovf0;
  logic [31:0] a0, b0, c0, d0;
  logic [15:0] total0;

  nb_update_engine dut0 (
    .clock(clock), .reset(reset0), .start(start0), .steps(steps0), .seq_mode(seq0),
    .load_valid(lv0), .load_sel(sel0), .load_data(data0), .load_ready(ready0),
    .busy(busy0), .done(done0), .a(a0), .b(b0), .c(c0), .d(d0), .ovf(ovf0),
    .ovf_clr(clr0), .total_steps(total0)
  );

  // Two 8-bit instances (wrap and saturate) sharing one stimulus
  logic        rst8 = 1'b1, start8 = 1'b0, seq8 = 1'b0, lv8 = 1'b0, clr8 = 1'b0;
  logic [15:0] steps8 = '0;
  logic [1:0]  sel8 = '0;
  logic [7:0]  data8 = '0;
  logic        ready_w, busy_w, done_w, ovf_w, ready_s, busy_s, done_s, ovf_s;
  logic [7:0]  aw, bw, cw, dw, as_, bs, cs, ds;
  logic [15:0] total_w, total_s;

  nb_update_engine #(.WIDTH(8), .SATURATE(0)) dut_w (
    .clock(clock), .reset(rst8), .start(start8), .steps(steps8), .seq_mode(seq8),
    .load_valid(lv8), .load_sel(sel8), .load_data(data8), .load_ready(ready_w),
    .busy(busy_w), .done(done_w), .a(aw), .b(bw), .c(cw), .d(dw), .ovf(ovf_w),
    .ovf_clr(clr8), .total_steps(total_w)
  );

  nb_update_engine #(.WIDTH(8), .SATURATE(1)) dut_s (
    .clock(clock), .reset(rst8), .start(start8), .steps(steps8), .seq_mode(seq8),
    .load_valid(lv8), .load_sel(sel8), .load_data(data8), .load_ready(ready_s),
    .busy(busy_s), .done(done_s), .a(as_), .b(bs), .c(cs), .d(ds), .ovf(ovf_s),
    .ovf_clr(clr8), .total_steps(total_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic spurious(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: done pulse with no expected transaction", name);
  endtask

  function automatic exp_t mk(input int a, input int b, input int c, input int d, input int o, input int t);
    exp_t e;
    e.a = 32'(a); e.b = 32'(b); e.c = 32'(c); e.d = 32'(d); e.ovf = 32'(o); e.total = 32'(t);
    return e;
  endfunction

  // Monitors
  always @(negedge clock) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) spurious("dut0_done");
      else begin
        e = q0.pop_front();
        check("dut0_a", a0, e.a);
        check("dut0_b", b0, e.b);
        check("dut0_c", c0, e.c);
        check("dut0_d", d0, e.d);
        check("dut0_ovf", 32'(ovf0), e.ovf);
        check("dut0_total", 32'(total0), e.total);
        $display("txn dut0 a=%0d b=%0d c=%0d d=%0d ovf=%0d total=%0d", a0, b0, c0, d0, ovf0, total0);
      end
    end
  end

  always @(negedge clock) begin : monw
    exp_t e;
    if (done_w) begin
      if (qw.size() == 0) spurious("wrap_done");
      else begin
        e = qw.pop_front();
        check("wrap_a", 32'(aw), e.a);
        check("wrap_b", 32'(bw), e.b);
        check("wrap_c", 32'(cw), e.c);
        check("wrap_d", 32'(dw), e.d);
        check("wrap_ovf", 32'(ovf_w), e.ovf);
        check("wrap_total", 32'(total_w), e.total);
        $display("txn wrap a=%0d b=%0d c=%0d d=%0d ovf=%0d total=%0d", aw, bw, cw, dw, ovf_w, total_w);
      end
    end
  end

  always @(negedge clock) begin : mons
    exp_t e;
    if (done_s) begin
      if (qs.size() == 0) spurious("sat_done");
      else begin
        e = qs.pop_front();
        check("sat_a", 32'(as_), e.a);
        check("sat_b", 32'(bs), e.b);
        check("sat_c", 32'(cs), e.c);
        check("sat_d", 32'(ds), e.d);
        check("sat_ovf", 32'(ovf_s), e.ovf);
        check("sat_total", 32'(total_s), e.total);
        $display("txn sat a=%0d b=%0d c=%0d d=%0d ovf=%0d total=%0d", as_, bs, cs, ds, ovf_s, total_s);
      end
    end
  end

  task automatic do_reset0();
    reset0 = 1'b1;
    @(negedge clock);
    reset0 = 1'b0;
  endtask

  // Starts a run on dut0 and measures start-to-done latency; optionally requests a load of a=99 during RUN.
  task automatic run0(input int s, input logic mode, input logic ld_run);
    int cycles = 0;
    start0 = 1'b1;
    steps0 = 16'(s);
    seq0   = mode;
    for (int i = 1; i <= 200 && cycles == 0; i++) begin
      @(negedge clock);
      start0 = 1'b0;
      lv0    = ld_run;
      if (busy0) check("load_ready_in_run", 32'(ready0), 32'd0);
      if (done0) cycles = i;
    end
    lv0 = 1'b0;
    check("latency", 32'(cycles), 32'(s + 1));
    @(negedge clock);
    check("done_one_cycle", 32'(done0), 32'd0);
  endtask

  initial begin
    int cycles;
    @(negedge clock);
    check("load_ready_in_reset", 32'(ready0), 32'd0);
    reset0 = 1'b0;
    rst8   = 1'b0;
    @(negedge clock);
    check("rst_a", a0, 32'd30);
    check("rst_b", b0, 32'd20);
    check("rst_c", c0, 32'd15);
    check("rst_d", d0, 32'd5);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_ovf", 32'(ovf0), 32'd0);
    check("rst_total", 32'(total0), 32'd0);
    check("rst_load_ready", 32'(ready0), 32'd1);

    // Parallel, one and two steps
    q0.push_back(mk(35, 15, 16, 27, 0, 1));
    run0(1, 1'b0, 1'b0);
    do_reset0();
    q0.push_back(mk(31, 37, 17, 32, 0, 2));
    run0(2, 1'b0, 1'b0);

    // Sequential one step, then a zero-step run leaves everything unchanged
    do_reset0();
    q0.push_back(mk(35, 42, 16, 32, 0, 1));
    run0(1, 1'b1, 1'b0);
    q0.push_back(mk(35, 42, 16, 32, 0, 1));
    run0(0, 1'b0, 1'b0);

    // Load request during RUN is ignored
    do_reset0();
    sel0  = 2'd0;
    data0 = 32'd99;
    q0.push_back(mk(54, 42, 18, 28, 0, 3));
    run0(3, 1'b0, 1'b1);

    // Load and start in the same cycle: the first update sees the loaded a
    do_reset0();
    lv0   = 1'b1;
    sel0  = 2'd0;
    data0 = 32'd100;
    q0.push_back(mk(35, 15, 16, 97, 0, 1));
    run0(1, 1'b0, 1'b0);
    lv0   = 1'b1;
    sel0  = 2'd2;
    data0 = 32'd5;
    @(negedge clock);
    lv0 = 1'b0;
    check("load_c", c0, 32'd5);
    q0.push_back(mk(20, 27, 6, 17, 0, 2));
    run0(1, 1'b1, 1'b0);

    // Reset in the third RUN cycle aborts the run
    do_reset0();
    start0 = 1'b1;
    steps0 = 16'd10;
    seq0   = 1'b0;
    @(negedge clock);
    start0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort_busy_before", 32'(busy0), 32'd1);
    reset0 = 1'b1;
    @(negedge clock);
    reset0 = 1'b0;
    check("abort_a", a0, 32'd30);
    check("abort_b", b0, 32'd20);
    check("abort_c", c0, 32'd15);
    check("abort_d", d0, 32'd5);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_done", 32'(done0), 32'd0);
    check("abort_total", 32'(total0), 32'd0);
    repeat (15) @(negedge clock);

    // 8-bit wrap vs saturate: load c=255, a=1, one parallel step
    check("w8_ovf_init", 32'(ovf_w), 32'd0);
    check("s8_ovf_init", 32'(ovf_s), 32'd0);
    lv8   = 1'b1;
    sel8  = 2'd2;
    data8 = 8'd255;
    @(negedge clock);
    sel8  = 2'd0;
    data8 = 8'd1;
    @(negedge clock);
    lv8 = 1'b0;
    for (int r = 0; r < 2; r++) begin
      if (r == 0) begin
        qw.push_back(mk(19, 15, 0, 254, 1, 1));
        qs.push_back(mk(255, 15, 255, 0, 1, 1));
      end else begin
        // Clear held across the run: a fresh overflow must still set the flag
        clr8 = 1'b1;
        qw.push_back(mk(15, 8, 1, 16, 1, 2));
        qs.push_back(mk(255, 10, 255, 252, 1, 2));
      end
      start8 = 1'b1;
      steps8 = 16'd1;
      seq8   = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 50 && cycles == 0; i++) begin
        @(negedge clock);
        start8 = 1'b0;
        if (done_w) cycles = i;
      end
      check("w8_latency", 32'(cycles), 32'd2);
      clr8 = 1'b0;
      @(negedge clock);
      check("w8_ovf_sticky", 32'(ovf_w), 32'd1);
      check("s8_ovf_sticky", 32'(ovf_s), 32'd1);
    end
    clr8 = 1'b1;
    @(negedge clock);
    clr8 = 1'b0;
    check("w8_ovf_clr", 32'(ovf_w), 32'd0);
    check("s8_ovf_clr", 32'(ovf_s), 32'd0);

    repeat (3) @(negedge clock);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("qw_drained", 32'(qw.size()), 32'd0);
    check("qs_drained", 32'(qs.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
